axi_rd_slv: RTL and testbench

AXI4 read-channel responder. Accepts read bursts on AR and returns data beats on R, fetched from a single-port synchronous SRAM read port. It is the slave endpoint behind the AXI register slices, so an initiator's AR/R traffic terminates on local memory. A 2-entry prefetch buffer sustains one beat per cycle under continuous `rready` and absorbs R back-pressure without losing SRAM data.

---
 rtl/axi_rd_slv.sv | 189 ++++++++++++++++++
 tb/tb_axi_rd_slv.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_slv.sv
// AXI4 read-channel responder backed by a single-port synchronous SRAM.
// A 2-entry prefetch FIFO keeps one beat per cycle flowing and soaks up R back-pressure.
module axi_rd_slv #(
    parameter int DW  = 64,
    parameter int IW  = 4,
    parameter int MAW = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IW-1:0]  s_arid,
    input  logic [31:0]    s_araddr,
    input  logic [7:0]     s_arlen,
    input  logic [1:0]     s_arburst,
    input  logic           s_arvalid,
    output logic           s_arready,
    output logic [IW-1:0]  s_rid,
    output logic [DW-1:0]  s_rdata,
    output logic [1:0]     s_rresp,
    output logic           s_rlast,
    output logic           s_rvalid,
    input  logic           s_rready,
    output logic           mem_en,
    output logic [MAW-1:0] mem_addr,
    input  logic [DW-1:0]  mem_rdata,
    output logic [1:0]     o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t         r_state;
    state_t         w_state_n;
    logic [IW-1:0]  r_id;
    logic [MAW-1:0] r_addr;
    logic           r_fixed;
    logic [8:0]     r_issue_cnt;
    logic [8:0]     r_ret_cnt;
    logic           r_inflight;
    logic           r_inflight_last;

    logic [DW-1:0]  r_buf_data [2];
    logic [1:0]     r_buf_last;
    logic           r_wptr;
    logic           r_rptr;
    logic [1:0]     r_count;

    logic           w_ar_hs;
    logic           w_pop;
    logic           w_push;
    logic           w_issue;
    logic           w_head_last;
    logic [2:0]     w_occ;
    logic           w_unused;

    // Address bits outside the SRAM word range carry no meaning here.
    assign w_unused = ^{s_araddr[31:MAW+3], s_araddr[2:0]};

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // while s_rvalid=1 and s_rready=0 every R output holds its value.
    assign w_ar_hs     = s_arready & s_arvalid;
    assign w_pop       = s_rvalid & s_rready;
    assign w_push      = r_inflight;
    assign w_head_last = r_buf_last[r_rptr];
    assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight};

    // A pop frees a slot this cycle, so a full pipe can still issue back-to-back.
    assign w_issue = !rst && (r_state == S_BURST) && (r_issue_cnt != 9'd0)
                     && ((w_occ < 3'd2) || w_pop);

    assign o_dbg_state = r_state;

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_ar_hs) begin
                    w_state_n = s_arburst[1] ? S_ERR : S_BURST;
                end
            end
            S_BURST: begin
                if (w_pop && w_head_last) begin
                    w_state_n = S_IDLE;
                end
            end
            S_ERR: begin
                if (w_pop && (r_ret_cnt == 9'd1)) begin
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        s_rresp   = RESP_OKAY;
        s_rdata   = '0;
        s_rid     = '0;
        mem_en    = w_issue;
        mem_addr  = '0;
        if (!rst) begin
            mem_addr = r_addr;
            unique case (r_state)
                S_IDLE: begin
                    s_arready = 1'b1;
                end
                S_BURST: begin
                    s_rid = r_id;
                    if (r_count != 2'd0) begin
                        s_rvalid = 1'b1;
                        s_rdata  = r_buf_data[r_rptr];
                        s_rlast  = w_head_last;
                    end
                end
                S_ERR: begin
                    s_rid    = r_id;
                    s_rvalid = 1'b1;
                    s_rresp  = RESP_SLVERR;
                    s_rlast  = (r_ret_cnt == 9'd1);
                end
                default: begin
                    s_arready = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_id            <= '0;
            r_addr          <= '0;
            r_fixed         <= 1'b0;
            r_issue_cnt     <= '0;
            r_ret_cnt       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_buf_last      <= '0;
            r_wptr          <= 1'b0;
            r_rptr          <= 1'b0;
            r_count         <= '0;
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
            end
        end else begin
            r_state <= w_state_n;

            if (w_ar_hs) begin
                r_id        <= s_arid;
                r_addr      <= s_araddr[MAW+2:3];
                r_fixed     <= (s_arburst == 2'b00);
                r_issue_cnt <= {1'b0, s_arlen} + 9'd1;
                r_ret_cnt   <= {1'b0, s_arlen} + 9'd1;
            end else if (w_issue) begin
                r_issue_cnt <= r_issue_cnt - 9'd1;
                if (!r_fixed) begin
                    r_addr <= r_addr + MAW'(1);
                end
            end

            if ((r_state == S_ERR) && w_pop) begin
                r_ret_cnt <= r_ret_cnt - 9'd1;
            end

            // SRAM data lands one cycle after the read enable.
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_issue_cnt == 9'd1);

            if (w_push) begin
                r_buf_data[r_wptr] <= mem_rdata;
                r_buf_last[r_wptr] <= r_inflight_last;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop && (r_state == S_BURST)) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + 2'(w_push) - 2'((r_state == S_BURST) && w_pop);
        end
    end

endmodule

// File: tb/tb_axi_rd_slv.sv
// Directed bench for axi_rd_slv: SRAM model preloaded with mem[k]=k, scoreboard of expected beats.
module tb_axi_rd_slv;
  localparam int DW  = 64;
  localparam int IW  = 4;
  localparam int MAW = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [IW-1:0]  s_arid = '0;
  logic [31:0]    s_araddr = '0;
  logic [7:0]     s_arlen = '0;
  logic [1:0]     s_arburst = '0;
  logic           s_arvalid = 1'b0;
  logic           s_arready;
  logic [IW-1:0]  s_rid;
  logic [DW-1:0]  s_rdata;
  logic [1:0]     s_rresp;
  logic           s_rlast;
  logic           s_rvalid;
  logic           s_rready = 1'b0;
  logic           mem_en;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_rdata = '0;
  logic [1:0]     o_dbg_state;

  logic [DW-1:0]  mem [1024];
  logic [DW-1:0]  exp_q[$];
  logic [MAW-1:0] addr_q[$];
  int             n_checks = 0;
  int             n_fail = 0;
  int             n_issue = 0;
  int             outst = 0;
  int             max_outst = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  axi_rd_slv #(.DW(DW), .IW(IW), .MAW(MAW)) dut (
    .clk(clk), .rst(rst),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .o_dbg_state(o_dbg_state)
  );

  // SRAM model: one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  // issue / outstanding monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      outst = 0;
    end else begin
      if (mem_en) begin
        n_issue++;
        addr_q.push_back(mem_addr);
      end
      outst = outst + int'(mem_en) - int'(s_rvalid && s_rready && (s_rresp == 2'b00));
      if (outst > max_outst) max_outst = outst;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic rr_pat(input int mode, input int c);
    int idx;
    idx = (c - 1) % 4;
    if (mode == 0) return 1'b1;
    return (idx == 0) || (idx == 3);
  endfunction

  // driver tasks: called and return at posedge+1
  task automatic ar(input logic [IW-1:0] id, input logic [31:0] addr,
                    input logic [7:0] len, input logic [1:0] burst);
    int k;
    k = 0;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arburst = burst; s_arvalid = 1'b1;
    @(negedge clk);
    while (!s_arready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ar_accept", 64'(s_arready), 64'd1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
  endtask

  task automatic collect(input int n, input int mode, input logic [IW-1:0] id,
                         input logic [1:0] resp, input int first_lat);
    int got, cyc, first, prev;
    bit stalled;
    logic [DW-1:0] hd, e;
    logic hl;
    got = 0; cyc = 0; first = 0; prev = 0; stalled = 0; hd = '0; hl = 1'b0;
    s_rready = rr_pat(mode, 1);
    while (got < n && cyc < 2000) begin
      cyc++;
      @(negedge clk);
      if (stalled) begin
        check("stall_valid", 64'(s_rvalid), 64'd1);
        check("stall_data", s_rdata, hd);
        check("stall_last", 64'(s_rlast), 64'(hl));
      end
      stalled = 0;
      if (s_rvalid) begin
        if (first == 0) first = cyc;
        if (s_rready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          check("rdata", s_rdata, e);
          check("rlast", 64'(s_rlast), 64'(got == n - 1));
          check("rid", 64'(s_rid), 64'(id));
          check("rresp", 64'(s_rresp), 64'(resp));
          if (mode == 0 && got > 0) check("beat_gap", 64'(cyc - prev), 64'd1);
          prev = cyc;
          got++;
        end else begin
          stalled = 1;
          hd = s_rdata;
          hl = s_rlast;
        end
      end
      @(posedge clk); #1;
      s_rready = rr_pat(mode, cyc + 1);
    end
    check("beats", 64'(got), 64'(n));
    check("first_rvalid", 64'(first), 64'(first_lat));
    s_rready = 1'b0;
    @(negedge clk);
    check("arready_after", 64'(s_arready), 64'd1);
    check("rvalid_after", 64'(s_rvalid), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic reset_window(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_ctl"}, 64'({s_arready, s_rvalid, s_rlast, s_rresp, mem_en}), 64'd0);
      check({tag, "_rid_addr"}, 64'({s_rid, mem_addr}), 64'd0);
      check({tag, "_rdata"}, s_rdata, 64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_arready_post"}, 64'(s_arready), 64'd1);
    check({tag, "_rvalid_post"}, 64'(s_rvalid), 64'd0);
    check({tag, "_state_post"}, 64'(o_dbg_state), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int i0, a0, seen;
    for (int k = 0; k < 1024; k++) mem[k] = 64'(k);

    // power-on reset
    reset_window("por");

    // INCR 0x40 len 3, full throughput: beats 8..11 from T+3
    for (int i = 0; i < 4; i++) exp_q.push_back(64'(8 + i));
    i0 = n_issue;
    ar(4'h5, 32'h40, 8'd3, 2'b01);
    collect(4, 0, 4'h5, 2'b00, 3);
    check("incr_issues", 64'(n_issue - i0), 64'd4);

    // same burst under toggling back-pressure
    for (int i = 0; i < 4; i++) exp_q.push_back(64'(8 + i));
    ar(4'hA, 32'h40, 8'd3, 2'b01);
    collect(4, 1, 4'hA, 2'b00, 3);
    check("max_outstanding", 64'(max_outst), 64'd2);

    // FIXED 0x18 len 2: three beats of mem[3], mem_addr 3 each issue
    for (int i = 0; i < 3; i++) exp_q.push_back(64'd3);
    a0 = addr_q.size();
    ar(4'h3, 32'h18, 8'd2, 2'b00);
    collect(3, 0, 4'h3, 2'b00, 3);
    check("fixed_issues", 64'(addr_q.size() - a0), 64'd3);
    for (int i = a0; i < addr_q.size(); i++) check("fixed_addr", 64'(addr_q[i]), 64'd3);

    // INCR wrap at top of SRAM: mem[1023] then mem[0]
    exp_q.push_back(64'd1023);
    exp_q.push_back(64'd0);
    ar(4'h7, 32'h1FF8, 8'd1, 2'b01);
    collect(2, 0, 4'h7, 2'b00, 3);

    // 256-beat INCR from word 256
    for (int i = 0; i < 256; i++) exp_q.push_back(64'(256 + i));
    ar(4'hC, 32'h800, 8'd255, 2'b01);
    collect(256, 0, 4'hC, 2'b00, 3);

    // WRAP -> SLVERR, two zero beats from T+1, no SRAM access
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);
    i0 = n_issue;
    ar(4'h9, 32'h40, 8'd1, 2'b10);
    collect(2, 0, 4'h9, 2'b10, 1);
    check("err_no_mem", 64'(n_issue - i0), 64'd0);

    // reserved burst type, single beat
    exp_q.push_back(64'd0);
    ar(4'h2, 32'h0, 8'd0, 2'b11);
    collect(1, 0, 4'h2, 2'b10, 1);

    // normal AR after error: single-beat INCR at word 2
    exp_q.push_back(64'd2);
    ar(4'h1, 32'h10, 8'd0, 2'b01);
    collect(1, 0, 4'h1, 2'b00, 3);

    // reset during a stalled burst
    ar(4'h6, 32'h0, 8'd15, 2'b01);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    reset_window("midrst");
    s_rready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (s_rvalid) seen++;
      @(posedge clk); #1;
    end
    check("no_stale_beats", 64'(seen), 64'd0);
    s_rready = 1'b0;

    // clean burst after reset: words 4,5
    exp_q.push_back(64'd4);
    exp_q.push_back(64'd5);
    ar(4'hE, 32'h20, 8'd1, 2'b01);
    collect(2, 0, 4'hE, 2'b00, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
